// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order write-back buffer draining one entry per clk into the Reg_file write port.
// Define WBQ_BYPASS_EN to forward queued, not-yet-written data onto rdata1/rdata2.
module regfile_wb_queue #(
  parameter int W     = 8,
  parameter int N     = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb_valid,
  input  logic [N-1:0]               wb_reg,
  input  logic [W-1:0]               wb_data,
  output logic                       wb_ready,
  input  logic                       rf_hold,
  output logic                       write,
  output logic [N-1:0]               wreg,
  output logic [W-1:0]               wdata,
  input  logic [N-1:0]               rreg1,
  input  logic [N-1:0]               rreg2,
  input  logic [W-1:0]               rf_rdata1,
  input  logic [W-1:0]               rf_rdata2,
  output logic [W-1:0]               rdata1,
  output logic [W-1:0]               rdata2,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [N-1:0]  reg_q [DEPTH];
  logic [N-1:0]  reg_d [DEPTH];
  logic [W-1:0]  dat_q [DEPTH];
  logic [W-1:0]  dat_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          enq, deq;
  always_comb begin
    wb_ready  = count_q < FULL;
    write     = (count_q != '0) && !rf_hold;
    wreg      = (count_q != '0) ? reg_q[head_q] : '0;
    wdata     = (count_q != '0) ? dat_q[head_q] : '0;
    occupancy = count_q;
  end
  always_comb begin
    enq   = wb_valid && wb_ready;
    deq   = write;
    reg_d = reg_q;
    dat_d = dat_q;
    if (enq) begin
      reg_d[tail_q] = wb_reg;
      dat_d[tail_q] = wb_data;
    end
    head_d  = deq ? head_q + AW'(1) : head_q;
    tail_d  = enq ? tail_q + AW'(1) : tail_q;
    count_d = count_q + (AW+1)'(enq) - (AW+1)'(deq);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      reg_q   <= '{default: '0};
      dat_q   <= '{default: '0};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      reg_q   <= reg_d;
      dat_q   <= dat_d;
    end
  end
`ifdef WBQ_BYPASS_EN
  logic [AW-1:0] idx;
  // Walk oldest to youngest so the last hit (youngest) wins; the head being drained still counts.
  always_comb begin
    rdata1 = rf_rdata1;
    rdata2 = rf_rdata2;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + AW'(k);
      if ((AW+1)'(k) < count_q) begin
        if (reg_q[idx] == rreg1) rdata1 = dat_q[idx];
        if (reg_q[idx] == rreg2) rdata2 = dat_q[idx];
      end
    end
  end
`else
  assign rdata1 = rf_rdata1;
  assign rdata2 = rf_rdata2;
`endif
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: randomized bench with a queue-based reference model and a Reg_file model.
module tb_regfile_wb_queue;
  localparam int W = 8, N = 5, DEPTH = 4;
  logic clk = 0, reset = 0, wb_valid = 0, rf_hold = 0;
  logic [N-1:0] wb_reg = 0, rreg1 = 0, rreg2 = 0;
  logic [W-1:0] wb_data = 0;
  logic wb_ready, write;
  logic [N-1:0] wreg;
  logic [W-1:0] wdata, rdata1, rdata2, rf_rdata1, rf_rdata2;
  logic [$clog2(DEPTH):0] occupancy;
  int n_vec = 0, n_bad = 0;
  bit acc;

  regfile_wb_queue #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .wb_ready(wb_ready), .rf_hold(rf_hold), .write(write), .wreg(wreg), .wdata(wdata),
    .rreg1(rreg1), .rreg2(rreg2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rdata1(rdata1), .rdata2(rdata2), .occupancy(occupancy));

  always #5 clk = ~clk;

  // Reg_file stand-in, written only through the DUT write port
  logic [W-1:0] rf_mem [2**N] = '{default: '0};
  assign rf_rdata1 = rf_mem[rreg1];
  assign rf_rdata2 = rf_mem[rreg2];
  always @(posedge clk) if (reset && write) rf_mem[wreg] <= wdata;

  typedef struct packed { logic [N-1:0] r; logic [W-1:0] d; } ent_t;
  ent_t q[$];
  logic [W-1:0] rf_exp [2**N] = '{default: '0};

  always @(posedge clk or negedge reset) begin
    if (!reset) q.delete();
    else begin
      automatic bit dw = q.size() > 0 && !rf_hold;
      automatic bit de = wb_valid && q.size() < DEPTH;
      automatic ent_t e = {wb_reg, wb_data};
      if (dw) begin
        rf_exp[q[0].r] = q[0].d;
        void'(q.pop_front());
      end
      if (de) q.push_back(e);
    end
  end

  function automatic logic [W-1:0] exp_rd(input logic [N-1:0] rr);
    logic [W-1:0] r;
    r = rf_exp[rr];
`ifdef WBQ_BYPASS_EN
    foreach (q[i]) if (q[i].r == rr) r = q[i].d;
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("wb_ready", wb_ready, q.size() < DEPTH);
    chk("occupancy", occupancy, q.size());
    chk("write", write, q.size() > 0 && !rf_hold);
    chk("wreg", wreg, q.size() ? q[0].r : '0);
    chk("wdata", wdata, q.size() ? q[0].d : '0);
    chk("rdata1", rdata1, exp_rd(rreg1));
    chk("rdata2", rdata2, exp_rd(rreg2));
    chk("rf_contents", rf_mem[rreg1], rf_exp[rreg1]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int r, input int d);
    wb_valid = 1;
    wb_reg   = N'(r);
    wb_data  = W'(d);
  endtask

  initial begin
    wb_valid = 1; wb_reg = 9; wb_data = 8'h33;
    #8;
    chk("rst_write", write, 0);
    chk("rst_wreg", wreg, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_ready", wb_ready, 1);
    chk("rst_occ", occupancy, 0);
    #4 reset = 1; wb_valid = 0;
    @(negedge clk);
    chk("rst_nothing_queued", occupancy, 0);
    tick();
    offer(7, 8'hA5);
    tick();
    wb_valid = 0;
    @(negedge clk);
    chk("single_write", write, 1);
    chk("single_wreg", wreg, 7);
    chk("single_wdata", wdata, 8'hA5);
    tick();
    @(negedge clk);
    chk("single_rf7", rf_mem[7], 8'hA5);
    chk("single_occ", occupancy, 0);
    tick();
    rf_hold = 1;
    offer(3, 8'h11);
    tick();
    offer(3, 8'h22);
    tick();
    wb_valid = 0; rreg1 = 3; rreg2 = 3;
    @(negedge clk);
`ifdef WBQ_BYPASS_EN
    chk("bypass_rd1", rdata1, 8'h22);
    chk("bypass_rd2", rdata2, 8'h22);
`else
    chk("bypass_rd1", rdata1, 8'h00);
    chk("bypass_rd2", rdata2, 8'h00);
`endif
    tick();
    rf_hold = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("bypass_drained_rf3", rf_mem[3], 8'h22);
    tick();
    rf_hold = 1;
    for (int i = 1; i <= 4; i++) begin
      offer(i, i * 10);
      tick();
    end
    offer(5, 50);
    @(negedge clk);
    chk("fill_occ", occupancy, 4);
    chk("fill_ready", wb_ready, 0);
    tick();
    rf_hold = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("stall_write", write, 1);
      chk("stall_wreg", wreg, j + 1);
      chk("stall_wdata", wdata, (j + 1) * 10);
      if (j == 1) chk("stall_ready", wb_ready, 1);
      tick();
      if (j == 1) wb_valid = 0;
    end
    @(negedge clk);
    chk("stall_last_wreg", wreg, 5);
    chk("stall_last_wdata", wdata, 50);
    repeat (3) tick();
    rf_hold = 1;
    for (int i = 0; i < 4; i++) begin
      offer(i, $urandom_range(0, 255));
      tick();
    end
    offer(4, $urandom_range(0, 255));
    @(negedge clk);
    rf_hold = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      acc = wb_ready;
      tick();
      if (acc) offer($urandom_range(0, 7), $urandom_range(0, 255));
    end
    @(negedge clk);
    chk("simul_occ", occupancy, 3);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc = wb_valid && wb_ready;
      tick();
      if (!wb_valid || acc) begin
        wb_valid = $urandom_range(0, 9) < 6;
        wb_reg   = N'($urandom_range(0, 7));
        wb_data  = W'($urandom_range(0, 255));
      end
      rf_hold = $urandom_range(0, 9) < 3;
      rreg1   = N'($urandom_range(0, 7));
      rreg2   = N'($urandom_range(0, 7));
    end
    wb_valid = 0; rf_hold = 0;
    repeat (6) tick();
    rf_hold = 1;
    for (int i = 20; i <= 22; i++) begin
      offer(i, i);
      tick();
    end
    wb_valid = 0;
    @(negedge clk);
    chk("midrst_occ_before", occupancy, 3);
    tick();
    #2 reset = 0;
    #1;
    chk("midrst_write", write, 0);
    chk("midrst_occ", occupancy, 0);
    chk("midrst_ready", wb_ready, 1);
    chk("midrst_wreg", wreg, 0);
    @(negedge clk);
    #2 reset = 1; rf_hold = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("midrst_rf20", rf_mem[20], 0);
    chk("midrst_rf21", rf_mem[21], 0);
    chk("midrst_rf22", rf_mem[22], 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
